// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : multi_edge_detector
// Purpose  : Multi-channel debounced edge detector. Each channel has a
//            stability filter. The filter feeds registered rising and falling
//            edge pulses, each gated by its own per-channel enable. A sticky
//            pending flag is kept per channel, and a saturating aggregate
//            counter totals the reported edges.
// Ports    : clk            - clock, all logic on rising edge
//            reset          - synchronous active-high reset
//            data_i         - WIDTH channel inputs (already synchronous to clk)
//            rise_en_i      - per-channel rising-edge reporting enable
//            fall_en_i      - per-channel falling-edge reporting enable
//            pend_clr_i     - per-channel clear of pending_o
//            count_clr_i    - clear of edge_count_o
//            rising_edge_o  - 1-cycle pulse per accepted, enabled rising edge
//            falling_edge_o - 1-cycle pulse per accepted, enabled falling edge
//            pending_o      - sticky enabled-edge flags
//            any_pending_o  - OR of pending_o
//            edge_count_o   - saturating count of reported edges
// Revision : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] pend_clr_i,
  input  logic             count_clr_i,
  output logic [WIDTH-1:0] rising_edge_o,
  output logic [WIDTH-1:0] falling_edge_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             any_pending_o,
  output logic [CNT_W-1:0] edge_count_o
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int NW = $clog2(WIDTH + 1);
  // The sum needs one bit more than the wider of its operands so that an
  // overflow past full scale can be detected before saturating.
  localparam int SW = ((CNT_W > NW) ? CNT_W : NW) + 1;
  localparam logic [FW-1:0]    C_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NW-1:0]    n_evt;
  logic [CNT_W-1:0] count_base;
  logic [SW-1:0]    count_sum;

  // Per-channel stability filter. The counter tracks how many consecutive
  // samples have differed from the stable level. Any matching sample
  // restarts it.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [FW-1:0] cnt_q, cnt_d;

      assign accept[i]   = (data_i[i] != stable_q[i]) && (cnt_q == C_LAST);
      assign stable_d[i] = accept[i] ? data_i[i] : stable_q[i];
      assign cnt_d       = ((data_i[i] == stable_q[i]) || accept[i])
                           ? '0 : cnt_q + 1'b1;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  // On an accept event the new level is the current input sample.
  assign rise_d = accept &  data_i & rise_en_i;
  assign fall_d = accept & ~data_i & fall_en_i;

  // A new event outranks a simultaneous clear, so the flag stays set.
  assign pend_d = (pend_q & ~pend_clr_i) | rise_d | fall_d;

  // A channel can never rise and fall on the same edge, so counting the OR
  // gives the total number of new pulses.
  always_comb begin
    n_evt = '0;
    for (int j = 0; j < WIDTH; j++) begin
      n_evt = n_evt + NW'(rise_d[j] | fall_d[j]);
    end
  end

  assign count_base = count_clr_i ? '0 : count_q;
  assign count_sum  = SW'(count_base) + SW'(n_evt);
  assign count_d    = (count_sum > SW'(C_MAX)) ? C_MAX : count_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      count_q  <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
    end
  end

  assign rising_edge_o  = rise_q;
  assign falling_edge_o = fall_q;
  assign pending_o      = pend_q;
  assign any_pending_o  = |pend_q;
  assign edge_count_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_edge_detector
// Purpose  : Directed self-checking bench for multi_edge_detector. Instance A
//            uses the default parameters (WIDTH=8, F=4, CNT_W=16). Instance B
//            uses WIDTH=8, F=1, CNT_W=4 to exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic [7:0]  a_data = '0, a_ren = '0, a_fen = '0, a_pclr = '0;
  logic        a_cclr = 1'b0;
  logic [7:0]  a_rise, a_fall, a_pend;
  logic        a_any;
  logic [15:0] a_cnt;

  logic [7:0]  b_data = '0, b_ren = '0, b_fen = '0, b_pclr = '0;
  logic        b_cclr = 1'b0;
  logic [7:0]  b_rise, b_fall, b_pend;
  logic        b_any;
  logic [3:0]  b_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(.WIDTH(8), .FILTER_CYCLES(4), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .data_i(a_data), .rise_en_i(a_ren),
    .fall_en_i(a_fen), .pend_clr_i(a_pclr), .count_clr_i(a_cclr),
    .rising_edge_o(a_rise), .falling_edge_o(a_fall), .pending_o(a_pend),
    .any_pending_o(a_any), .edge_count_o(a_cnt)
  );

  multi_edge_detector #(.WIDTH(8), .FILTER_CYCLES(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .data_i(b_data), .rise_en_i(b_ren),
    .fall_en_i(b_fen), .pend_clr_i(b_pclr), .count_clr_i(b_cclr),
    .rising_edge_o(b_rise), .falling_edge_o(b_fall), .pending_o(b_pend),
    .any_pending_o(b_any), .edge_count_o(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_a(input string tag, input logic [7:0] r, input logic [7:0] f,
                         input logic [7:0] p, input logic [15:0] c);
    check({tag, ".rise"}, 32'(a_rise), 32'(r));
    check({tag, ".fall"}, 32'(a_fall), 32'(f));
    check({tag, ".pend"}, 32'(a_pend), 32'(p));
    check({tag, ".any"},  32'(a_any),  32'(p != 8'h00));
    check({tag, ".cnt"},  32'(a_cnt),  32'(c));
  endtask

  initial begin
    // ---------------- reset with random inputs ----------------
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'($urandom); a_ren = 8'($urandom); a_fen = 8'($urandom);
      a_pclr = 8'($urandom); a_cclr = 1'($urandom);
      b_data = 8'($urandom); b_ren = 8'($urandom); b_fen = 8'($urandom);
      b_pclr = 8'($urandom); b_cclr = 1'($urandom);
      tick();
    end
    check_a("reset_a", 8'h00, 8'h00, 8'h00, 16'd0);
    check("reset_b.rise", 32'(b_rise), 32'h0);
    check("reset_b.fall", 32'(b_fall), 32'h0);
    check("reset_b.pend", 32'(b_pend), 32'h0);
    check("reset_b.cnt",  32'(b_cnt),  32'h0);

    reset = 1'b0;
    a_data = '0; a_ren = 8'hFF; a_fen = 8'h00; a_pclr = '0; a_cclr = 1'b0;
    b_data = '0; b_ren = 8'hFF; b_fen = 8'hFF; b_pclr = '0; b_cclr = 1'b0;
    tick(); tick();
    check_a("idle", 8'h00, 8'h00, 8'h00, 16'd0);

    // ---------------- ch0 rise, F=4: pulse on 4th high sample ----------------
    a_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("rise_wait", 8'h00, 8'h00, 8'h00, 16'd0);
    end
    tick();
    check_a("rise_pulse", 8'h01, 8'h00, 8'h01, 16'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_a("rise_after", 8'h00, 8'h00, 8'h01, 16'd1);
    end

    // pending clear, then counter clear
    a_pclr = 8'h01; tick(); a_pclr = '0;
    check_a("pclr", 8'h00, 8'h00, 8'h00, 16'd1);
    a_cclr = 1'b1; tick(); a_cclr = 1'b0;
    check_a("cclr", 8'h00, 8'h00, 8'h00, 16'd0);

    // ---------------- glitch: ch2 high for 3 samples ----------------
    a_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("glitch_hi", 8'h00, 8'h00, 8'h00, 16'd0);
    end
    a_data = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a("glitch_lo", 8'h00, 8'h00, 8'h00, 16'd0);
    end

    // ---------------- masking: only falls on ch5 reported ----------------
    a_ren = 8'h00; a_fen = 8'hFF;
    a_data = 8'h21;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_a("mask_hi", 8'h00, 8'h00, 8'h00, 16'd0);
    end
    a_data = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("mask_lo_wait", 8'h00, 8'h00, 8'h00, 16'd0);
    end
    tick();
    check_a("mask_fall", 8'h00, 8'h20, 8'h20, 16'd1);
    tick(); tick();
    check_a("mask_after", 8'h00, 8'h00, 8'h20, 16'd1);

    // ---------------- pending set/clear priority on ch1 ----------------
    a_ren = 8'hFF; a_fen = 8'h00;
    a_pclr = 8'hFF; tick(); a_pclr = '0;
    check_a("prio_pre", 8'h00, 8'h00, 8'h00, 16'd1);
    a_data = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("prio_wait", 8'h00, 8'h00, 8'h00, 16'd1);
    end
    a_pclr = 8'h02;
    tick();
    check_a("prio_setwins", 8'h02, 8'h00, 8'h02, 16'd2);
    tick();
    check_a("prio_clear", 8'h00, 8'h00, 8'h00, 16'd2);
    a_pclr = '0;

    // ---------------- counter saturation on instance B (F=1, CNT_W=4) ----------------
    b_data = 8'hFF; tick();
    check("sat1.rise", 32'(b_rise), 32'hFF);
    check("sat1.cnt",  32'(b_cnt),  32'd8);
    b_data = 8'h00; tick();
    check("sat2.fall", 32'(b_fall), 32'hFF);
    check("sat2.cnt",  32'(b_cnt),  32'd15);
    check("sat2.any",  32'(b_any),  32'd1);
    b_data = 8'hFF; tick();
    check("sat3.cnt",  32'(b_cnt),  32'd15);
    b_data = 8'h00; tick();
    check("sat4.cnt",  32'(b_cnt),  32'd15);
    tick();
    check("sat_hold.cnt",  32'(b_cnt),  32'd15);
    check("sat_hold.fall", 32'(b_fall), 32'h00);
    b_cclr = 1'b1; b_data = 8'h07; tick(); b_cclr = 1'b0;
    check("clr_load.rise", 32'(b_rise), 32'h07);
    check("clr_load.cnt",  32'(b_cnt),  32'd3);
    tick();
    check("clr_after.cnt", 32'(b_cnt),  32'd3);

    // ---------------- reset mid-filter on instance A ----------------
    a_data = 8'h07;
    tick(); tick();
    check_a("mid_filter", 8'h00, 8'h00, 8'h00, 16'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    check_a("mid_reset", 8'h00, 8'h00, 8'h00, 16'd0);
    check("mid_reset_b.cnt", 32'(b_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("mid_wait", 8'h00, 8'h00, 8'h00, 16'd0);
      if (i == 0) check("mid_b.rise", 32'(b_rise), 32'h07);
    end
    tick();
    check_a("mid_pulse", 8'h07, 8'h00, 8'h07, 16'd3);
    tick();
    check_a("mid_after", 8'h00, 8'h00, 8'h07, 16'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
